// File: rtl/sb_bus_pkg.sv
// Shared system-bus definitions: slave FSM states, bus field widths and the
// address-window decode used by memory-mapped targets.
package sb_bus_pkg;

  localparam int SB_DATA_W  = 32;
  localparam int SB_BE_W    = 4;
  localparam int SB_BURST_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    RD_END,
    WR_BURST,
    ERR
  } sb_state_e;

  // A window of 2**addr_bits words is selected by every byte-address bit above it.
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input int unsigned addr_bits);
    int unsigned sh;
    sh = addr_bits + 2;
    return (addr >> sh) == (base >> sh);
  endfunction

endpackage

// File: rtl/sb_bram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// one-cycle read; contents are not initialised or cleared by reset.
module sb_bram_be #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_W    = 32
) (
  input  logic                  i_clk,
  input  logic [ADDR_BITS-1:0]  i_addr,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/sb_mem_slave.sv
// SRAM target on the shared system bus: decodes its address window and serves
// single/burst reads and writes, driving the wired-OR slave return signals.
module sb_mem_slave
  import sb_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 4,
  parameter int          BUSY_PERIOD  = 0
) (
  input  logic                   sb_clock_i,
  input  logic                   sb_reset_n_i,
  input  logic                   sb_begin_transaction_i,
  input  logic [SB_DATA_W-1:0]   sb_address_data_i,
  input  logic [SB_BE_W-1:0]     sb_byte_enables_i,
  input  logic [SB_BURST_W-1:0]  sb_burst_size_i,
  input  logic                   sb_read_n_write_i,
  input  logic                   sb_data_valid_i,
  input  logic                   sb_end_transaction_i,
  input  logic                   sb_error_i,
  output logic [SB_DATA_W-1:0]   sb_address_data_o,
  output logic                   sb_data_valid_o,
  output logic                   sb_end_transaction_o,
  output logic                   sb_busy_o,
  output logic                   sb_error_o
);

  localparam int          LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [15:0] BUSY_LAST = 16'((BUSY_PERIOD > 0) ? BUSY_PERIOD - 1 : 0);
  localparam logic [31:0] LAST_WORD = 32'((1 << ADDR_BITS) - 1);

  sb_state_e               r_state;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [SB_BE_W-1:0]      r_be;
  logic [SB_BURST_W-1:0]   r_burst;
  logic [SB_BURST_W-1:0]   r_beat;
  logic [LAT_W-1:0]        r_lat;
  logic [15:0]             r_busyCnt;
  logic                    r_full;
  logic                    r_dv;
  logic                    r_end;
  logic                    r_busy;
  logic                    r_err;

  logic                    w_hit;
  logic [ADDR_BITS-1:0]    w_wordAddr;
  logic [31:0]             w_endWord;
  logic                    w_beginErr;
  logic                    w_abort;
  logic                    w_wrBeat;
  logic                    w_wrAccept;
  logic                    w_wrExcess;
  logic                    w_re;
  logic [SB_DATA_W-1:0]    w_ramRdata;

  assign w_hit      = sb_begin_transaction_i && win_hit(sb_address_data_i, BASE_ADDR, ADDR_BITS);
  assign w_wordAddr = sb_address_data_i[ADDR_BITS+1:2];
  assign w_endWord  = 32'(w_wordAddr) + 32'(sb_burst_size_i);
  assign w_beginErr = (sb_address_data_i[1:0] != 2'b00) || (w_endWord > LAST_WORD);

  // End-of-transaction only aborts reads; writes treat it as normal completion.
  assign w_abort = (r_state != IDLE) &&
                   (sb_error_i || (sb_end_transaction_i &&
                                   (r_state == RD_WAIT || r_state == RD_BURST)));

  assign w_wrBeat   = (r_state == WR_BURST) && sb_data_valid_i && !r_busy && !sb_error_i;
  assign w_wrAccept = w_wrBeat && !r_full;
  assign w_wrExcess = w_wrBeat && r_full;

  assign w_re = ((r_state == RD_WAIT) && (r_lat == LAT_LAST)) ||
                ((r_state == RD_BURST) && (r_beat != r_burst));

  sb_bram_be #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (SB_DATA_W)
  ) u_ram (
    .i_clk   (sb_clock_i),
    .i_addr  (r_addr),
    .i_we    (w_wrAccept),
    .i_be    (r_be),
    .i_wdata (sb_address_data_i),
    .i_re    (w_re),
    .o_rdata (w_ramRdata)
  );

  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
      r_busyCnt <= '0;
      r_full    <= 1'b0;
      r_dv      <= 1'b0;
      r_end     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_end  <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        r_dv    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_dv <= 1'b0;
            if (w_hit) begin
              r_addr    <= w_wordAddr;
              r_be      <= sb_byte_enables_i;
              r_burst   <= sb_burst_size_i;
              r_beat    <= '0;
              r_lat     <= '0;
              r_busyCnt <= '0;
              r_full    <= 1'b0;
              if (w_beginErr) begin
                r_state <= ERR;
                r_err   <= 1'b1;
              end else if (sb_read_n_write_i) begin
                r_state <= RD_WAIT;
              end else begin
                r_state <= WR_BURST;
              end
            end
          end
          RD_WAIT: begin
            if (r_lat == LAT_LAST) begin
              r_state <= RD_BURST;
              r_dv    <= 1'b1;
              r_addr  <= r_addr + 1'b1;
            end else begin
              r_lat <= r_lat + 1'b1;
            end
          end
          RD_BURST: begin
            if (r_beat == r_burst) begin
              r_state <= RD_END;
              r_dv    <= 1'b0;
              r_end   <= 1'b1;
            end else begin
              r_beat <= r_beat + 8'd1;
              r_addr <= r_addr + 1'b1;
            end
          end
          RD_END: r_state <= IDLE;
          WR_BURST: begin
            // The last accepted beat leaves the address parked so it never wraps.
            if (w_wrAccept) begin
              if (r_beat == r_burst) begin
                r_full <= 1'b1;
              end else begin
                r_beat <= r_beat + 8'd1;
                r_addr <= r_addr + 1'b1;
              end
              if (BUSY_PERIOD > 0) begin
                if (r_busyCnt == BUSY_LAST) begin
                  r_busy    <= 1'b1;
                  r_busyCnt <= '0;
                end else begin
                  r_busyCnt <= r_busyCnt + 16'd1;
                end
              end
            end
            if (w_wrExcess) r_err <= 1'b1;
            if (sb_end_transaction_i) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          ERR:     r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sb_address_data_o    = r_dv ? w_ramRdata : '0;
  assign sb_data_valid_o      = r_dv;
  assign sb_end_transaction_o = r_end;
  assign sb_busy_o            = r_busy;
  assign sb_error_o           = r_err;

endmodule
